// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave sequencing controller.
package microwave_pkg;

    localparam int BCD_W   = 4;
    localparam int DIGITS  = 3;
    localparam int ENTRY_W = BCD_W * DIGITS;

    typedef enum logic [1:0] {IDLE, COOK, PAUSED, DONE} state_t;

    typedef struct packed {
        logic             valid;
        logic [BCD_W-1:0] digit;
    } key_t;

    // bit k is digit k+1 for k=0..8, bit 9 is digit 0; anything but exactly one hot is invalid
    function automatic key_t key_decode(input logic [9:0] keys);
        key_t r;
        int   hot;
        r   = '0;
        hot = 0;
        for (int k = 0; k < 10; k++) begin
            if (keys[k]) begin
                hot++;
                r.digit = (k == 9) ? 4'd0 : 4'(k + 1);
            end
        end
        r.valid = (hot == 1);
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_clamp_tens(input logic [BCD_W-1:0] tens);
        return (tens > 4'd5) ? 4'd5 : tens;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second strobe generator: counts 0..TICKS_PER_SEC-1 while enabled, freezes on hold.
module sec_prescaler
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int               CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && !hold && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !hold) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/microwave_ctrl.sv
// Front-panel sequencer: m:ss entry, start/stop/clear/door handling, per-second timer strobes.
//  state  | meaning
//  IDLE   | accepting keypad entry, display shows entry digits
//  COOK   | magnetron on, one timer_dec per second
//  PAUSED | stopped or door opened mid-cook, prescaler frozen
//  DONE   | timer reached 0:00, done lit until start/stop/door opening
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         keypad,
    input  logic               startn,
    input  logic               stopn,
    input  logic               clearn,
    input  logic               door_closed,
    input  logic               timer_zero,
    output logic               timer_load,
    output logic [ENTRY_W-1:0] timer_data,
    output logic               timer_dec,
    output logic               mag,
    output logic               disp_sel,
    output logic               done
);

    state_t             state;
    logic [ENTRY_W-1:0] entry;
    logic               start_prev, stop_prev, clear_prev, door_prev, key_idle;
    key_t               key;
    logic               start_press, stop_press, clear_press, door_opened, key_press;
    logic               zero_seen, leave_cook, start_ok, tick;
    logic [ENTRY_W-1:0] load_value;

    assign key         = key_decode(keypad);
    assign start_press = !startn && !start_prev;
    assign stop_press  = !stopn && !stop_prev;
    assign clear_press = !clearn && !clear_prev;
    assign door_opened = door_prev && !door_closed;
    assign key_press   = key_idle && key.valid;
    // the timer only sees the new value one edge after timer_load, so its zero flag is stale then
    assign zero_seen   = timer_zero && !timer_load;
    assign leave_cook  = clear_press || zero_seen || !door_closed || stop_press;
    assign start_ok    = (state == IDLE) && start_press && door_closed && (entry != '0);
    assign load_value  = {entry[ENTRY_W-1 -: BCD_W], bcd_clamp_tens(entry[2*BCD_W-1 -: BCD_W]),
                          entry[BCD_W-1:0]};

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (state == COOK),
        .clear  (start_ok || clear_press),
        .hold   (leave_cook),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            entry      <= '0;
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
            clear_prev <= 1'b0;
            door_prev  <= 1'b0;
            key_idle   <= 1'b1;
            timer_load <= 1'b0;
            timer_data <= '0;
            timer_dec  <= 1'b0;
            mag        <= 1'b0;
            disp_sel   <= 1'b0;
            done       <= 1'b0;
        end else begin
            start_prev <= !startn;
            stop_prev  <= !stopn;
            clear_prev <= !clearn;
            door_prev  <= door_closed;
            key_idle   <= (keypad == '0);
            timer_load <= 1'b0;
            timer_dec  <= 1'b0;

            if (clear_press) begin
                state      <= IDLE;
                entry      <= '0;
                timer_load <= 1'b1;
                timer_data <= '0;
                mag        <= 1'b0;
                disp_sel   <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state      <= COOK;
                            timer_load <= 1'b1;
                            timer_data <= load_value;
                            entry      <= '0;
                            mag        <= 1'b1;
                            disp_sel   <= 1'b1;
                        end else if (key_press && !start_press) begin
                            entry <= {entry[2*BCD_W-1:0], key.digit};
                        end
                    end
                    COOK: begin
                        if (zero_seen) begin
                            state <= DONE;
                            mag   <= 1'b0;
                            done  <= 1'b1;
                        end else if (!door_closed || stop_press) begin
                            state <= PAUSED;
                            mag   <= 1'b0;
                        end else begin
                            timer_dec <= tick;
                        end
                    end
                    PAUSED: begin
                        if (start_press && door_closed) begin
                            state <= COOK;
                            mag   <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (start_press || stop_press || door_opened) begin
                            state    <= IDLE;
                            done     <= 1'b0;
                            disp_sel <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: scenario tasks against an arithmetic reference model.
module tb_microwave_ctrl;

    localparam int TPS = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  keypad = '0;
    logic        startn = 1'b1;
    logic        stopn = 1'b1;
    logic        clearn = 1'b1;
    logic        door_closed = 1'b1;
    logic        timer_zero = 1'b0;
    logic        timer_load;
    logic [11:0] timer_data;
    logic        timer_dec;
    logic        mag;
    logic        disp_sel;
    logic        done;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          dec_q[$];
    logic [11:0] m_entry = '0;

    microwave_ctrl #(.TICKS_PER_SEC(TPS)) dut (
        .clk         (clk),
        .rst         (rst),
        .keypad      (keypad),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .timer_load  (timer_load),
        .timer_data  (timer_data),
        .timer_dec   (timer_dec),
        .mag         (mag),
        .disp_sel    (disp_sel),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (timer_dec) dec_q.push_back(cyc);

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // entry m:ss with the seconds-tens digit limited to 5
    function automatic logic [11:0] exp_load(input logic [11:0] e);
        logic [3:0] tens;
        tens = (e[7:4] > 4'd5) ? 4'd5 : e[7:4];
        return {e[11:8], tens, e[3:0]};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_key(input int d);
        keypad = (d == 0) ? 10'b10_0000_0000 : (10'd1 << (d - 1));
        step(2);
        keypad = '0;
        step(1);
        m_entry = {m_entry[7:0], 4'(d)};
    endtask

    task automatic pulse_start();
        startn = 1'b0;
        step(1);
        startn = 1'b1;
    endtask

    task automatic do_clear(input string tag);
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        m_entry = '0;
        n_cmp++; if (timer_load !== 1'b1) begin n_bad++; $display("FAIL %s_clear_load: got %b want 1", tag, timer_load); end
        n_cmp++; if (timer_data !== 12'h000) begin n_bad++; $display("FAIL %s_clear_data: got %h want 000", tag, timer_data); end
        n_cmp++; if (disp_sel !== 1'b0) begin n_bad++; $display("FAIL %s_clear_disp: got %b want 0", tag, disp_sel); end
        n_cmp++; if (mag !== 1'b0) begin n_bad++; $display("FAIL %s_clear_mag: got %b want 0", tag, mag); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_clear_done: got %b want 0", tag, done); end
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_cmp++; if (timer_load !== 1'b0) begin n_bad++; $display("FAIL reset_load: got %b want 0", timer_load); end
        n_cmp++; if (timer_data !== 12'h000) begin n_bad++; $display("FAIL reset_data: got %h want 000", timer_data); end
        n_cmp++; if (timer_dec !== 1'b0) begin n_bad++; $display("FAIL reset_dec: got %b want 0", timer_dec); end
        n_cmp++; if (mag !== 1'b0) begin n_bad++; $display("FAIL reset_mag: got %b want 0", mag); end
        n_cmp++; if (disp_sel !== 1'b0) begin n_bad++; $display("FAIL reset_disp: got %b want 0", disp_sel); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        m_entry = '0;
        step(1);
    endtask

    // Cook, pause at t_pause clocks after the start edge, resume, and check strobe timing.
    // A strobe lands on every 50th cooking clock; start/resume and pausing edges are not cooking clocks.
    task automatic test_cook_timing(input int t_pause, input bit use_door, input int d0, input int d1, input int d2);
        logic [11:0] exp;
        int          s_cyc, r_cyc, n_exp, first_gap;
        press_key(d0);
        press_key(d1);
        press_key(d2);
        exp = exp_load(m_entry);
        dec_q.delete();
        pulse_start();
        s_cyc = cyc;
        m_entry = '0;
        n_cmp++; if (timer_load !== 1'b1) begin n_bad++; $display("FAIL cook_load: got %b want 1", timer_load); end
        n_cmp++; if (timer_data !== exp) begin n_bad++; $display("FAIL cook_data: got %h want %h", timer_data, exp); end
        n_cmp++; if (mag !== 1'b1) begin n_bad++; $display("FAIL cook_mag: got %b want 1", mag); end
        n_cmp++; if (disp_sel !== 1'b1) begin n_bad++; $display("FAIL cook_disp: got %b want 1", disp_sel); end
        step(t_pause - 1);
        if (use_door) door_closed = 1'b0;
        else stopn = 1'b0;
        step(1);
        stopn = 1'b1;
        n_cmp++; if (mag !== 1'b0) begin n_bad++; $display("FAIL pause_mag: got %b want 0 (door=%0b)", mag, use_door); end
        n_cmp++; if (disp_sel !== 1'b1) begin n_bad++; $display("FAIL pause_disp: got %b want 1", disp_sel); end
        step(20);
        n_exp = (t_pause - 1) / TPS;
        n_cmp++;
        if (dec_q.size() != n_exp) begin
            n_bad++; $display("FAIL cook_dec_count: got %0d want %0d (t_pause %0d)", dec_q.size(), n_exp, t_pause);
        end else begin
            for (int j = 0; j < n_exp; j++) begin
                n_cmp++;
                if (dec_q[j] != s_cyc + TPS * (j + 1)) begin
                    n_bad++; $display("FAIL cook_dec_time%0d: got %0d want %0d", j, dec_q[j] - s_cyc, TPS * (j + 1));
                end
            end
        end
        if (use_door) begin
            pulse_start();
            n_cmp++; if (mag !== 1'b0) begin n_bad++; $display("FAIL start_door_open_mag: got %b want 0", mag); end
            door_closed = 1'b1;
            step(1);
        end
        dec_q.delete();
        pulse_start();
        r_cyc = cyc;
        n_cmp++; if (mag !== 1'b1) begin n_bad++; $display("FAIL resume_mag: got %b want 1", mag); end
        for (int i = 0; i < 2 * TPS && dec_q.size() == 0; i++) step(1);
        first_gap = TPS - ((t_pause - 1) % TPS);
        n_cmp++;
        if (dec_q.size() != 1) begin
            n_bad++; $display("FAIL resume_dec_count: got %0d want 1", dec_q.size());
        end else if (dec_q[0] != r_cyc + first_gap) begin
            n_bad++; $display("FAIL resume_dec_time: got %0d want %0d", dec_q[0] - r_cyc, first_gap);
        end
        do_clear("cook");
    endtask

    task automatic test_zero_entry();
        pulse_start();
        n_cmp++; if (timer_load !== 1'b0) begin n_bad++; $display("FAIL zero_entry_load: got %b want 0", timer_load); end
        step(1);
        n_cmp++; if (mag !== 1'b0) begin n_bad++; $display("FAIL zero_entry_mag: got %b want 0", mag); end
        press_key(9);
        press_key(9);
        pulse_start();
        n_cmp++; if (timer_load !== 1'b1) begin n_bad++; $display("FAIL clamp_load: got %b want 1", timer_load); end
        n_cmp++; if (timer_data !== 12'h059) begin n_bad++; $display("FAIL clamp_data: got %h want 059", timer_data); end
        do_clear("clamp");
    endtask

    task automatic test_done_stop();
        press_key($urandom_range(1, 9));
        pulse_start();
        m_entry = '0;
        step($urandom_range(10, 90));
        timer_zero = 1'b1;
        stopn = 1'b0;
        step(1);
        stopn = 1'b1;
        dec_q.delete();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL done_set: got %b want 1", done); end
        n_cmp++; if (mag !== 1'b0) begin n_bad++; $display("FAIL done_mag: got %b want 0", mag); end
        n_cmp++; if (disp_sel !== 1'b1) begin n_bad++; $display("FAIL done_disp: got %b want 1", disp_sel); end
        step(2 * TPS);
        n_cmp++; if (dec_q.size() != 0) begin n_bad++; $display("FAIL done_no_dec: got %0d strobes want 0", dec_q.size()); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL done_hold: got %b want 1", done); end
        pulse_start();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_exit: got %b want 0", done); end
        n_cmp++; if (disp_sel !== 1'b0) begin n_bad++; $display("FAIL done_exit_disp: got %b want 0", disp_sel); end
        timer_zero = 1'b0;
        step(1);
    endtask

    task automatic test_clear_paused();
        press_key($urandom_range(1, 9));
        pulse_start();
        m_entry = '0;
        step(30);
        stopn = 1'b0;
        step(1);
        stopn = 1'b1;
        step(3);
        do_clear("paused");
        keypad = 10'b00_0000_0011;
        step(2);
        keypad = '0;
        step(1);
        pulse_start();
        n_cmp++; if (timer_load !== 1'b0) begin n_bad++; $display("FAIL multihot_load: got %b want 0", timer_load); end
        n_cmp++; if (mag !== 1'b0) begin n_bad++; $display("FAIL multihot_mag: got %b want 0", mag); end
        step(1);
    endtask

    task automatic test_random_entries();
        logic        go;
        logic [11:0] exp;
        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) press_key($urandom_range(0, 9));
            door_closed = ($urandom_range(0, 3) != 0);
            step(1);
            go  = door_closed && (m_entry != 12'h000);
            exp = exp_load(m_entry);
            pulse_start();
            n_cmp++; if (timer_load !== go) begin n_bad++; $display("FAIL rand%0d_load: got %b want %b", it, timer_load, go); end
            n_cmp++; if (mag !== go) begin n_bad++; $display("FAIL rand%0d_mag: got %b want %b", it, mag, go); end
            if (go) begin
                n_cmp++; if (timer_data !== exp) begin n_bad++; $display("FAIL rand%0d_data: got %h want %h", it, timer_data, exp); end
            end
            door_closed = 1'b1;
            do_clear("rand");
        end
    endtask

    task automatic test_rst_mid_cook();
        press_key($urandom_range(1, 9));
        pulse_start();
        step(30);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        m_entry = '0;
        dec_q.delete();
        n_cmp++; if (mag !== 1'b0) begin n_bad++; $display("FAIL rst_cook_mag: got %b want 0", mag); end
        n_cmp++; if (disp_sel !== 1'b0) begin n_bad++; $display("FAIL rst_cook_disp: got %b want 0", disp_sel); end
        step(2 * TPS);
        n_cmp++; if (dec_q.size() != 0) begin n_bad++; $display("FAIL rst_cook_dec: got %0d strobes want 0", dec_q.size()); end
    endtask

    initial begin
        test_reset();
        test_cook_timing(120, 1'b1, 1, 4, 5);
        test_cook_timing($urandom_range(60, 140), 1'b0, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(1, 9));
        test_zero_entry();
        test_done_stop();
        test_clear_paused();
        test_random_entries();
        test_rst_mid_cook();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
